// File: rtl/inst_rom.sv
// Loadable instruction ROM: 2^AW x 32-bit words with per-word valid bits,
// filled from a little-endian byte stream and read by the fetch port with 1-cycle latency.
module inst_rom #(
    parameter int AW = 6
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
    input  logic [31:0]   addr,
    output logic [31:0]   inst,
    output logic          inst_valid,
    output logic          fetch_err,
    input  logic          ld_start,
    input  logic          ld_valid,
    input  logic [7:0]    ld_byte,
    input  logic          ld_end,
    output logic          ld_ready,
    output logic          ld_done,
    output logic [AW:0]   ld_words
);

    localparam int          DEPTH   = 1 << AW;
    localparam logic [31:0] NOP     = 32'h0000_0013;
    localparam logic [AW-1:0] PTR_MAX = {AW{1'b1}};
    localparam logic [AW:0]   WORDS_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic {
        ST_IDLE,
        ST_LOAD
    } state_t;

    // Output word selector, registered at the fetch edge and decoded afterwards.
    typedef enum logic [1:0] {
        OUT_ZERO,
        OUT_NOP,
        OUT_ERR,
        OUT_WORD
    } out_sel_t;

    state_t         state_reg, state_next;
    out_sel_t       out_sel_reg, out_sel_next;
    logic [1:0]     byte_cnt_reg, byte_cnt_next;
    logic [AW-1:0]  wr_ptr_reg, wr_ptr_next;
    logic [31:0]    word_buf_reg, word_buf_next;
    logic [AW:0]    ld_words_reg, ld_words_next;
    logic           ld_done_reg, ld_done_next;
    logic [DEPTH-1:0] valid_reg;
    logic [31:0]    rd_data_reg;

    logic [31:0]    mem [DEPTH];

    logic           accept;
    logic           wr_en;
    logic [31:0]    wr_data;
    logic           clr_valid;
    logic [31:0]    asm_word;
    logic [AW-1:0]  fetch_idx;
    logic           addr_bad;

    assign ld_ready  = (state_reg == ST_LOAD);
    assign accept    = ld_valid && ld_ready;
    assign fetch_idx = addr[AW+1:2];
    assign addr_bad  = (addr[1:0] != 2'b00) || (addr[31:AW+2] != '0);

    // Incoming byte lands in the lane selected by the byte counter; other lanes keep
    // what has been assembled so far (zero for lanes not yet filled).
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign asm_word[8*gi +: 8] = (byte_cnt_reg == 2'(gi)) ? ld_byte
                                                                   : word_buf_reg[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        byte_cnt_next = byte_cnt_reg;
        wr_ptr_next   = wr_ptr_reg;
        word_buf_next = word_buf_reg;
        ld_words_next = ld_words_reg;
        ld_done_next  = 1'b0;
        wr_en         = 1'b0;
        wr_data       = '0;
        clr_valid     = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (ld_start) begin
                    state_next    = ST_LOAD;
                    byte_cnt_next = '0;
                    wr_ptr_next   = '0;
                    word_buf_next = '0;
                    ld_words_next = '0;
                    clr_valid     = 1'b1;
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    if (byte_cnt_reg == 2'd3) begin
                        wr_en         = 1'b1;
                        wr_data       = asm_word;
                        ld_words_next = ld_words_reg + WORDS_ONE;
                        byte_cnt_next = '0;
                        word_buf_next = '0;
                        // Last word filled: finish without wrapping the pointer.
                        if (wr_ptr_reg == PTR_MAX) begin
                            state_next   = ST_IDLE;
                            ld_done_next = 1'b1;
                        end else begin
                            wr_ptr_next = wr_ptr_reg + 1'b1;
                        end
                    end else begin
                        byte_cnt_next = byte_cnt_reg + 2'd1;
                        word_buf_next = asm_word;
                    end
                end

                // A byte accepted this cycle is already folded into the *_next values,
                // so a terminating partial word includes it.
                if (ld_end && (state_next == ST_LOAD)) begin
                    state_next   = ST_IDLE;
                    ld_done_next = 1'b1;
                    if (byte_cnt_next != 2'd0) begin
                        wr_en         = 1'b1;
                        wr_data       = word_buf_next;
                        ld_words_next = ld_words_reg + WORDS_ONE;
                        byte_cnt_next = '0;
                        word_buf_next = '0;
                        if (wr_ptr_reg != PTR_MAX) begin
                            wr_ptr_next = wr_ptr_reg + 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Fetches only run in IDLE, and a fetch coinciding with ld_start is dropped.
    always_comb begin
        out_sel_next = OUT_ZERO;
        if ((state_reg == ST_IDLE) && ce && !ld_start) begin
            if (addr_bad) begin
                out_sel_next = OUT_ERR;
            end else if (!valid_reg[fetch_idx]) begin
                out_sel_next = OUT_NOP;
            end else begin
                out_sel_next = OUT_WORD;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            out_sel_reg  <= OUT_ZERO;
            byte_cnt_reg <= '0;
            wr_ptr_reg   <= '0;
            word_buf_reg <= '0;
            ld_words_reg <= '0;
            ld_done_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            out_sel_reg  <= out_sel_next;
            byte_cnt_reg <= byte_cnt_next;
            wr_ptr_reg   <= wr_ptr_next;
            word_buf_reg <= word_buf_next;
            ld_words_reg <= ld_words_next;
            ld_done_reg  <= ld_done_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr_valid) begin
            valid_reg <= '0;
        end else if (wr_en) begin
            valid_reg[wr_ptr_reg] <= 1'b1;
        end
    end

    // Storage array: one write port, one registered read port, no reset on data.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_data;
        end
        rd_data_reg <= mem[fetch_idx];
    end

    always_comb begin
        inst       = '0;
        inst_valid = 1'b0;
        fetch_err  = 1'b0;
        case (out_sel_reg)
            OUT_WORD: begin
                inst       = rd_data_reg;
                inst_valid = 1'b1;
            end
            OUT_NOP: begin
                inst = NOP;
            end
            OUT_ERR: begin
                inst      = NOP;
                fetch_err = 1'b1;
            end
            default: begin
                inst = '0;
            end
        endcase
    end

    assign ld_done  = ld_done_reg;
    assign ld_words = ld_words_reg;

endmodule
